stage1_fetch_unit: RTL
======================

# stage1_fetch_unit

Instruction-fetch half of stage 1: takes the PC from the stage-1 PC incrementer, reads instruction memory through a req/ack handshake, and loads the IF/ID pipeline register consumed by stage 2 (decode). It supports a variable-latency memory, decode back-pressure (Stall) and branch/jump redirect (Flush). It also generates PCWrite for the PC incrementer, so the PC advances only when an instruction is actually accepted or a redirect occurs.

## Interface
- DATA_WIDTH, 16, instruction width
- ADDR_WIDTH, 16, PC / memory address width
- NOP_INSTR, 16'h0000, value loaded into IR on bubble or flush
- CLK  in  1  rising-edge clock
- Reset  in  1  asynchronous, active-high reset
- PC  in  ADDR_WIDTH  current PC from the PC incrementer
- PCWrite  out  1  combinational; PC incrementer updates PC at this edge
- IMemReq  out  1  memory request, held high until IMemAck
- IMemAddr  out  ADDR_WIDTH  request address, stable while IMemReq=1 within a request
- IMemAck  in  1  one-cycle pulse; IMemData valid in the same cycle
- IMemData  in  DATA_WIDTH  instruction word
- Stall  in  1  decode cannot accept a new IR this cycle
- Flush  in  1  branch/jump taken; PC incrementer is loading a new target
- IR  out  DATA_WIDTH  IF/ID instruction register
- IRPC  out  ADDR_WIDTH  address of the instruction in IR
- IRValid  out  1  IR holds a real instruction

## Operation
- States: IDLE, REQ, HOLD, DRAIN. Reset enters IDLE. IDLE always goes to REQ on the next edge.
- IDLE:
  - IMemReq=0, PCWrite=0.
- REQ:
  - IMemReq=1, IMemAddr=PC.
  - ReqAddr<=PC every cycle.
- REQ with IMemAck and no Flush:
  - Stall=0: IR<=IMemData, IRPC<=PC, IRValid<=1, PCWrite=1. Stay in REQ.
  - Stall=1: Buf<=IMemData, BufPC<=PC, PCWrite=0. Go to HOLD.
- REQ with no ack, no Flush:
  - If Stall=0, IR<=NOP_INSTR and IRValid<=0 (bubble).
  - If Stall=1, IR/IRPC/IRValid hold.
- HOLD:
  - IMemReq=0.
  - When Stall=0: IR<=Buf, IRPC<=BufPC, IRValid<=1, PCWrite=1. Go to REQ.
- DRAIN:
  - IMemReq=1, IMemAddr=ReqAddr.
  - On IMemAck, discard IMemData and go to REQ.
  - IR holds NOP_INSTR with IRValid=0.
- Flush overrides Stall in every state. It sets IR<=NOP_INSTR, IRValid<=0, PCWrite=1.
  - Flush in REQ without ack: go to DRAIN; the outstanding request cannot be cancelled.
  - Flush in REQ with ack: discard the data, stay in REQ.
  - Flush in HOLD: discard Buf, go to REQ.
  - Flush in DRAIN: stay in DRAIN.
  - Flush in IDLE: go to REQ.
- IRPC is the fetched address, not PC+1.

## Timing
- Reset values, asserted asynchronously:
  - IR=NOP_INSTR, IRPC=0, IRValid=0.
  - IMemReq=0, PCWrite=0.
  - State=IDLE, Buf=0, BufPC=0, ReqAddr=0.
- First IMemReq is asserted in the first cycle after Reset deasserts plus one (the IDLE cycle).
- Zero-wait memory (ack in the request cycle): one instruction per cycle. IR is valid the cycle after ack.
- N-wait memory: N bubble cycles per instruction.
- PCWrite is high in exactly the cycles that load a valid IR or see Flush. It is never high twice for one fetched word.
- Reset mid-request drops the request immediately. The memory model is reset with the same signal.
- IMemAddr must not change while IMemReq=1 within one request, except when REQ re-issues after an accepted ack.

## Structure
- Package jala_fetch_pkg holds:
  - fetch_state_t (IDLE, REQ, HOLD, DRAIN)
  - NOP_INSTR default
  - ADDR_WIDTH/DATA_WIDTH defaults
- One sub-module, stage1_fetch_hold_buffer: the single-entry Buf/BufPC skid register with load/clear.
- The FSM, IF/ID register and PCWrite logic live in stage1_fetch_unit.
- A top-level schematic/wrapper connects PCWrite to the PC incrementer's PCWrite input.

## Test plan
- Reset, zero-wait memory returning IMemData = address+16'h1000 -> IRPC = 0,1,2,3… on consecutive cycles, IR = 16'h1000,16'h1001…, PCWrite high every REQ cycle.
- Memory with 2-cycle ack latency -> IRValid pattern 1,0,0 repeating; IMemAddr stable during each wait; PC advances once per word.
- Stall=1 for 3 cycles when ack arrives with PC=5 -> state HOLD, IMemReq=0, PCWrite=0; after Stall drops, IR=word@5, IRPC=5, PCWrite pulses once.
- Flush at PC=8 during a 3-cycle wait, PC redirected to 302 -> DRAIN; stale word@8 never appears in IR; the next valid IR has IRPC=302.
- Flush coincident with ack and with Stall=1 -> IRValid=0, IR=NOP_INSTR, PCWrite=1, no HOLD entry.
- Reset asserted mid-DRAIN -> all outputs at reset values asynchronously; one IDLE cycle, then IMemReq=1 with IMemAddr=PC.

Source files
------------

// File: rtl/jala_fetch_pkg.sv
// Shared types and default widths for the stage-1 instruction fetch unit.
package jala_fetch_pkg;
    localparam int          ADDR_WIDTH_DEF = 16;
    localparam int          DATA_WIDTH_DEF = 16;
    localparam logic [15:0] NOP_INSTR_DEF  = 16'h0000;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        HOLD,
        DRAIN
    } fetch_state_t;
endpackage

// File: rtl/stage1_fetch_unit_if.sv
// Instruction-memory req/ack bus between the fetch unit (master) and memory (slave).
interface stage1_fetch_unit_if import jala_fetch_pkg::*; #(
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
) ();
    logic                  IMemReq;
    logic [ADDR_WIDTH-1:0] IMemAddr;
    logic                  IMemAck;
    logic [DATA_WIDTH-1:0] IMemData;

    modport master (output IMemReq, output IMemAddr, input IMemAck, input IMemData);
    modport slave  (input IMemReq, input IMemAddr, output IMemAck, output IMemData);
endinterface

// File: rtl/stage1_fetch_hold_buffer.sv
// Single-entry skid register that parks a fetched word while decode is stalled.
module stage1_fetch_hold_buffer import jala_fetch_pkg::*; #(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
    input  logic                  CLK,
    input  logic                  Reset,
    input  logic                  load,
    input  logic                  clear,
    input  logic [DATA_WIDTH-1:0] data,
    input  logic [ADDR_WIDTH-1:0] pc,
    output logic [DATA_WIDTH-1:0] buf_data,
    output logic [ADDR_WIDTH-1:0] buf_pc
);
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            buf_data <= '0;
            buf_pc   <= '0;
        end else if (clear) begin
            buf_data <= '0;
            buf_pc   <= '0;
        end else if (load) begin
            buf_data <= data;
            buf_pc   <= pc;
        end
    end
endmodule

// File: rtl/stage1_fetch_unit.sv
// Stage-1 fetch: req/ack instruction read, IF/ID register, stall skid and flush drain.
module stage1_fetch_unit import jala_fetch_pkg::*; #(
    parameter int                    DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int                    ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter logic [DATA_WIDTH-1:0] NOP_INSTR  = DATA_WIDTH'(NOP_INSTR_DEF)
) (
    input  logic                   CLK,
    input  logic                   Reset,
    input  logic [ADDR_WIDTH-1:0]  PC,
    output logic                   PCWrite,
    stage1_fetch_unit_if.master    mem,
    input  logic                   Stall,
    input  logic                   Flush,
    output logic [DATA_WIDTH-1:0]  IR,
    output logic [ADDR_WIDTH-1:0]  IRPC,
    output logic                   IRValid
);
    fetch_state_t          state;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic                  buf_load;
    logic                  buf_clear;
    logic [DATA_WIDTH-1:0] buf_data;
    logic [ADDR_WIDTH-1:0] buf_pc;

    // DRAIN keeps presenting the address of the request that cannot be cancelled.
    assign mem.IMemReq  = (state == REQ) || (state == DRAIN);
    assign mem.IMemAddr = (state == DRAIN) ? req_addr : PC;

    assign buf_load  = (state == REQ) && mem.IMemAck && Stall && !Flush;
    assign buf_clear = (state == HOLD) && Flush;

    always_comb begin
        PCWrite = 1'b0;
        if (!Reset) begin
            if (Flush) begin
                PCWrite = 1'b1;
            end else begin
                case (state)
                    REQ:     PCWrite = mem.IMemAck && !Stall;
                    HOLD:    PCWrite = !Stall;
                    default: PCWrite = 1'b0;
                endcase
            end
        end
    end

    stage1_fetch_hold_buffer #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_hold (
        .CLK      (CLK),
        .Reset    (Reset),
        .load     (buf_load),
        .clear    (buf_clear),
        .data     (mem.IMemData),
        .pc       (PC),
        .buf_data (buf_data),
        .buf_pc   (buf_pc)
    );

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state    <= IDLE;
            IR       <= NOP_INSTR;
            IRPC     <= '0;
            IRValid  <= 1'b0;
            req_addr <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (Flush) begin
                        IR      <= NOP_INSTR;
                        IRValid <= 1'b0;
                    end
                    state <= REQ;
                end
                REQ: begin
                    req_addr <= PC;
                    if (Flush) begin
                        IR      <= NOP_INSTR;
                        IRValid <= 1'b0;
                        if (!mem.IMemAck) state <= DRAIN;
                    end else if (mem.IMemAck) begin
                        if (!Stall) begin
                            IR      <= mem.IMemData;
                            IRPC    <= PC;
                            IRValid <= 1'b1;
                        end else begin
                            state <= HOLD;
                        end
                    end else if (!Stall) begin
                        IR      <= NOP_INSTR;
                        IRValid <= 1'b0;
                    end
                end
                HOLD: begin
                    if (Flush) begin
                        IR      <= NOP_INSTR;
                        IRValid <= 1'b0;
                        state   <= REQ;
                    end else if (!Stall) begin
                        IR      <= buf_data;
                        IRPC    <= buf_pc;
                        IRValid <= 1'b1;
                        state   <= REQ;
                    end
                end
                DRAIN: begin
                    // An ack always ends the drain, even alongside a new Flush, so it cannot deadlock.
                    IR      <= NOP_INSTR;
                    IRValid <= 1'b0;
                    if (mem.IMemAck) state <= REQ;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
